// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, ALU operation codes and the
// control bundle carried from decode into execute.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 5;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD = 5'b00000,
    ALU_SUB = 5'b00001,
    ALU_AND = 5'b00010,
    ALU_OR  = 5'b00011,
    ALU_XOR = 5'b00100,
    ALU_SLL = 5'b00101,
    ALU_SRL = 5'b00110,
    ALU_SRA = 5'b00111,
    ALU_SLT = 5'b01000
  } alu_op_e;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [CTRL_W-1:0] alu_ctrl;
  } ex_ctrl_t;

endpackage

// File: rtl/fwd_select.sv
// Operand bypass mux: picks the youngest in-flight writer of a register
// (MEM before WB), falling back to the value held in the ID/EX register.
module fwd_select #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   stored,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   value
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired to zero, so a write targeting it must never be bypassed.
  assign mem_hit = mem_valid & mem_reg_write & (mem_rd == rs) & (rs != '0);
  assign wb_hit  = wb_valid  & wb_reg_write  & (wb_rd  == rs) & (rs != '0);

  always_comb begin
    value = stored;
    if (mem_hit) begin
      value = mem_result;
    end else if (wb_hit) begin
      value = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU, with MEM/WB operand forwarding
// and a one-cycle bubble on load-use dependencies.
module id_ex_operand_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW,
  parameter int CTRL_W = riscv_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_alu_src,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [CTRL_W-1:0] ex_alu_ctrl,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);

  import riscv_pkg::ex_ctrl_t;

  logic              valid_p1;
  logic [XLEN-1:0]   pc_p1;
  logic [REG_AW-1:0] rs1_p1;
  logic [REG_AW-1:0] rs2_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [XLEN-1:0]   rs1_data_p1;
  logic [XLEN-1:0]   rs2_data_p1;
  logic [XLEN-1:0]   imm_p1;
  ex_ctrl_t          ctrl_p1;

  logic              hazard;
  logic              wb_rs1_hit;
  logic              wb_rs2_hit;
  logic [XLEN-1:0]   rs1_capture;
  logic [XLEN-1:0]   rs2_capture;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  // A load in EX cannot supply its data until MEM, so a dependent decode
  // instruction must wait one cycle.
  assign hazard = valid_p1 & ctrl_p1.mem_read & (rd_p1 != '0) & id_valid &
                  ((id_use_rs1 & (id_rs1 == rd_p1)) | (id_use_rs2 & (id_rs2 == rd_p1)));
  assign id_ready = ~ex_stall & ~hazard;

  // The register file is written at the end of WB, so decode's read misses a
  // same-cycle WB write; patch it on the way in.
  assign wb_rs1_hit  = wb_valid & wb_reg_write & (wb_rd == id_rs1) & (id_rs1 != '0);
  assign wb_rs2_hit  = wb_valid & wb_reg_write & (wb_rd == id_rs2) & (id_rs2 != '0);
  assign rs1_capture = wb_rs1_hit ? wb_result : id_rs1_data;
  assign rs2_capture = wb_rs2_hit ? wb_result : id_rs2_data;

  // ---- ID -> EX register (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_p1    <= 1'b0;
      pc_p1       <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      ctrl_p1     <= '0;
    end else if (flush) begin
      valid_p1          <= 1'b0;
      ctrl_p1.reg_write <= 1'b0;
      ctrl_p1.mem_read  <= 1'b0;
      ctrl_p1.mem_write <= 1'b0;
    end else if (ex_stall) begin
      // Latch bypassed values so results draining out of MEM/WB survive the stall.
      rs1_data_p1 <= fwd_rs1;
      rs2_data_p1 <= fwd_rs2;
    end else if (hazard) begin
      valid_p1          <= 1'b0;
      ctrl_p1.reg_write <= 1'b0;
      ctrl_p1.mem_read  <= 1'b0;
      ctrl_p1.mem_write <= 1'b0;
    end else if (id_valid) begin
      valid_p1          <= 1'b1;
      pc_p1             <= id_pc;
      rs1_p1            <= id_rs1;
      rs2_p1            <= id_rs2;
      rd_p1             <= id_rd;
      rs1_data_p1       <= rs1_capture;
      rs2_data_p1       <= rs2_capture;
      imm_p1            <= id_imm;
      ctrl_p1.reg_write <= id_reg_write;
      ctrl_p1.mem_read  <= id_mem_read;
      ctrl_p1.mem_write <= id_mem_write;
      ctrl_p1.alu_src   <= id_alu_src;
      ctrl_p1.alu_ctrl  <= id_alu_ctrl;
    end else begin
      valid_p1          <= 1'b0;
      ctrl_p1.reg_write <= 1'b0;
      ctrl_p1.mem_read  <= 1'b0;
      ctrl_p1.mem_write <= 1'b0;
    end
  end

  // ---- EX operand select ----
  fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs            (rs1_p1),
    .stored        (rs1_data_p1),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .value         (fwd_rs1)
  );

  fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs            (rs2_p1),
    .stored        (rs2_data_p1),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .value         (fwd_rs2)
  );

  assign ex_valid      = valid_p1;
  assign ex_a          = fwd_rs1;
  assign ex_b          = ctrl_p1.alu_src ? imm_p1 : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_alu_ctrl   = ctrl_p1.alu_ctrl;
  assign ex_pc         = pc_p1;
  assign ex_rd         = rd_p1;
  assign ex_reg_write  = ctrl_p1.reg_write;
  assign ex_mem_read   = ctrl_p1.mem_read;
  assign ex_mem_write  = ctrl_p1.mem_write;

endmodule
